// File: rtl/mips_mmio_uart_tx.sv
// rtl/mips_mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Snoops the CPU data bus and claims three words at BASE_ADDR:
//   +0x0 TXDATA  write pushes wr_data[7:0] into the TX FIFO, reads 0
//   +0x4 STATUS  {20'b0, level[11:4], overflow[3], empty[2], full[1], busy[0]}
//                write with bit3=1 clears overflow
//   +0x8 CTRL    bit0 enable, bit1 parity enable (parity build only)
//
// Optional feature macro: MMIO_UART_PARITY_EN (adds an even-parity bit, 8E1).
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   mem_addr     CPU bus byte address (bits [1:0] ignored)
//   mem_wr_data  CPU bus write data
//   mem_wr_ena   CPU bus write strobe, one cycle per store
//   mmio_hit     combinational: address falls inside the register window
//   mmio_rd_data registered read data, 1-cycle latency
//   uart_tx      serial line, idle high
//   tx_busy      frame on the line or FIFO non-empty
module mips_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic        mmio_hit,
  output logic [31:0] mmio_rd_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level;
  logic           empty;
  logic           full;

  logic           enable;
  logic           overflow;
  logic           parity_en_rd;

  logic [29:0]    word_off;
  logic           wr_hit;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           baud_done;
  logic [31:0]    rd_mux;

  logic           unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wr_data[31:8]};

  // Unsigned word offset: addresses below the base wrap to huge values and miss.
  assign word_off = mem_addr[31:2] - BASE_ADDR[31:2];
  assign mmio_hit = (word_off < 30'd3);
  assign wr_hit   = mem_wr_ena & mmio_hit;

  assign empty     = (level == '0);
  assign full      = (level == DEPTH);
  assign pop       = (state == IDLE) & enable & ~empty;
  assign push_req  = wr_hit & (word_off[1:0] == 2'd0);
  // A push into a full FIFO still fits when the FSM frees a slot this cycle.
  assign push      = push_req & (~full | pop);
  assign tx_busy   = (state != IDLE) | ~empty;
  assign baud_done = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wr_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef MMIO_UART_PARITY_EN
  logic parity_en;
  logic parity_bit;
  assign parity_en_rd = parity_en;
`else
  assign parity_en_rd = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (word_off[1:0])
      2'd1:    rd_mux = {20'b0, 8'(level), overflow, empty, full, tx_busy};
      2'd2:    rd_mux = {30'b0, parity_en_rd, enable};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable       <= 1'b0;
      overflow     <= 1'b0;
      mmio_rd_data <= '0;
`ifdef MMIO_UART_PARITY_EN
      parity_en    <= 1'b0;
`endif
    end else begin
      mmio_rd_data <= mmio_hit ? rd_mux : '0;
      if (push_req & full & ~pop) begin
        overflow <= 1'b1;
      end else if (wr_hit && word_off[1:0] == 2'd1 && mem_wr_data[3]) begin
        overflow <= 1'b0;
      end
      if (wr_hit && word_off[1:0] == 2'd2) begin
        enable    <= mem_wr_data[0];
`ifdef MMIO_UART_PARITY_EN
        parity_en <= mem_wr_data[1];
`endif
      end
    end
  end

  // Serialiser; uart_tx is registered alongside the state so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      uart_tx    <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
`ifdef MMIO_UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            state      <= START;
            uart_tx    <= 1'b0;
            shift      <= fifo_mem[rd_ptr];
`ifdef MMIO_UART_PARITY_EN
            parity_bit <= ^fifo_mem[rd_ptr];
`endif
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            uart_tx  <= shift[0];
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              if (parity_en) begin
                state   <= PARITY;
                uart_tx <= parity_bit;
              end else begin
                state   <= STOP;
                uart_tx <= 1'b1;
              end
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef MMIO_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state    <= STOP;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mmio_uart_tx.sv
// tb/tb_mips_mmio_uart_tx.sv - scoreboard bench for mips_mmio_uart_tx
module tb_mips_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int CPB = 4;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_wr_ena = 1'b0;
  logic        mmio_hit;
  logic [31:0] mmio_rd_data;
  logic        uart_tx;
  logic        tx_busy;

  mips_mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena),
    .mmio_hit(mmio_hit),
    .mmio_rd_data(mmio_rd_data),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  bit rd_strobe = 1'b0;
  bit rd_take = 1'b0;
  bit rst_hit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Read-data monitor: one cycle after a read is presented, compare against the queue.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_take <= 1'b0;
    else     rd_take <= rd_strobe;
  end

  always @(negedge clk) begin
    if (rd_take) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%h required=none", mmio_rd_data);
      end else begin
        check("rd_data", mmio_rd_data, rd_q.pop_front());
      end
    end
  end

  always @(posedge rst) rst_hit = 1'b1;

  // Line monitor: decode each 8N1 frame mid-bit and compare with the expected byte queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        logic [7:0] got;
        logic ok_start;
        logic ok_stop;
        rst_hit = 1'b0;
        got = '0;
        @(negedge clk);
        ok_start = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        ok_stop = (uart_tx === 1'b1);
        if (!rst_hit) begin
          check("start_bit", {31'b0, ok_start}, 32'd1);
          check("stop_bit", {31'b0, ok_stop}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%h required=none", got);
          end else begin
            check("uart_byte", {24'b0, got}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_ena  = 1'b1;
    @(negedge clk);
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    mem_addr = a;
    rd_q.push_back(exp);
    rd_strobe = 1'b1;
    #1 check("mmio_hit", {31'b0, mmio_hit}, {31'b0, exp_hit});
    @(negedge clk);
    rd_strobe = 1'b0;
    mem_addr  = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, tx_busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_rd_data", mmio_rd_data, 32'd0);
    check("reset_busy", {31'b0, tx_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_ST, 32'h0000_0004, 1'b1);
    bus_read(A_CT, 32'h0, 1'b1);

    // Single byte 0xA5: start at the edge after the push, 40 clks of frame.
    bus_write(A_CT, 32'h1);
    bus_read(A_CT, 32'h1, 1'b1);
    exp_q.push_back(8'hA5);
    bus_write(A_TX, 32'h0000_00A5);
    check("line_before_start", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    check("line_start", {31'b0, uart_tx}, 32'd0);
    n = 1;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_clks", n, 32'd41);
    bus_read(A_ST, 32'h0000_0004, 1'b1);

    // Fill while disabled, overflow on the ninth write, W1C clear.
    bus_write(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(i));
    bus_read(A_ST, 32'h0000_008B, 1'b1);
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, 32'h0000_0083, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    bus_write(A_CT, 32'h1);
    wait_idle("overflow_drain");
    bus_read(A_ST, 32'h0000_0004, 1'b1);
    check("overflow_frames_left", exp_q.size(), 32'd0);

    // Push into a full FIFO on the same edge the FSM pops.
    bus_write(A_CT, 32'h0);
    for (int i = 0; i < 8; i++) bus_write(A_TX, 32'h10 + 32'(i));
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h10 + i));
    bus_write(A_CT, 32'h1);
    bus_write(A_TX, 32'h18);
    bus_read(A_ST, 32'h0000_0083, 1'b1);
    wait_idle("pushpop_drain");
    bus_read(A_ST, 32'h0000_0004, 1'b1);
    check("pushpop_frames_left", exp_q.size(), 32'd0);

    // Disable during data bit 3: frame completes, remaining two entries wait.
    bus_write(A_CT, 32'h0);
    bus_write(A_TX, 32'h21);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h23);
    exp_q.push_back(8'h21);
    bus_write(A_CT, 32'h1);
    repeat (17) @(negedge clk);
    bus_write(A_CT, 32'h0);
    repeat (100) @(negedge clk);
    check("disabled_frames_left", exp_q.size(), 32'd0);
    check("disabled_line_idle", {31'b0, uart_tx}, 32'd1);
    bus_read(A_ST, 32'h0000_0021, 1'b1);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h23);
    bus_write(A_CT, 32'h1);
    wait_idle("reenable_drain");
    check("reenable_frames_left", exp_q.size(), 32'd0);

    // Address decode edges.
    bus_read(BASE + 32'hC, 32'h0, 1'b0);
    bus_read(BASE - 32'h4, 32'h0, 1'b0);
    bus_read(A_TX, 32'h0, 1'b1);
    bus_write(A_CT, 32'h0);
    bus_write(BASE + 32'hC, 32'h77);
    bus_read(A_ST, 32'h0000_0004, 1'b1);

    // Reset in the middle of a frame (0x55, bit1 = 0 on the line).
    bus_write(A_TX, 32'h55);
    bus_write(A_CT, 32'h1);
    repeat (10) @(negedge clk);
    check("line_before_reset", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("midframe_reset_tx", {31'b0, uart_tx}, 32'd1);
    check("midframe_reset_rd", mmio_rd_data, 32'd0);
    check("midframe_reset_busy", {31'b0, tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_ST, 32'h0000_0004, 1'b1);
    bus_read(A_CT, 32'h0, 1'b1);
    repeat (60) @(negedge clk);
    check("final_frames_left", exp_q.size(), 32'd0);
    check("final_reads_left", rd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
